// File: rtl/hog_bus_responder.sv
// Bus-facing responder for HOG results: FIFO drain on word 0, CSR on word 1, level irq.
// Optional interrupt logic is compiled in when HOG_BUS_IRQ_EN is defined.
module hog_bus_responder #(
    parameter int BUS_WIDTH  = 128,
    parameter int ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_WIDTH-1:0]  addr,
    input  logic                   bus_enable,
    input  logic                   r_wbar,
    input  logic [BUS_WIDTH-1:0]   write_data,
    input  logic [BUS_WIDTH/8-1:0] byte_enable,
    output logic                   ack,
    output logic [BUS_WIDTH-1:0]   read_data,
    output logic                   irq,
    input  logic [BUS_WIDTH-1:0]   in_data,
    input  logic                   in_valid,
    output logic                   in_ready
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = ADDR_WIDTH - 4;

    typedef enum logic [1:0] {IDLE, RESP, WAIT} state_t;

    state_t                 state_reg;
    logic                   ack_reg;
    logic [BUS_WIDTH-1:0]   read_data_reg;
    logic [BUS_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_reg;
    logic [PTR_W-1:0]       rd_ptr_reg;
    logic [CNT_W-1:0]       count_reg;

    logic [IDX_W-1:0]       word_idx;
    logic                   start;
    logic                   empty;
    logic                   full;
    logic                   csr_wr;
    logic                   do_pop;
    logic                   do_push;
    logic                   do_flush;
    logic [31:0]            status_view;
    logic [31:0]            irq_en_view;
    logic [31:0]            irq_stat_view;
    logic [127:0]           csr_word;
    logic [BUS_WIDTH-1:0]   read_data_next;

    assign word_idx = addr[ADDR_WIDTH-1:4];
    assign start    = (state_reg == IDLE) && bus_enable;
    assign empty    = (count_reg == '0);
    assign full     = (count_reg == CNT_W'(FIFO_DEPTH));
    assign in_ready = !full;
    assign csr_wr   = start && !r_wbar && (word_idx == IDX_W'(1));
    assign do_pop   = start && r_wbar && (word_idx == '0) && !empty;
    assign do_flush = csr_wr && byte_enable[12] && write_data[96];
    // A flush in the same cycle discards the incoming word.
    assign do_push  = in_valid && !full && !do_flush;

    assign status_view = {16'h0, 8'(count_reg), 6'h0, full, empty};
    assign csr_word    = {32'h0, irq_stat_view, irq_en_view, status_view};

    always_comb begin
        read_data_next = '0;
        if (r_wbar) begin
            if (word_idx == '0) begin
                if (!empty) read_data_next = mem[rd_ptr_reg];
            end else if (word_idx == IDX_W'(1)) begin
                read_data_next = BUS_WIDTH'(csr_word);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            ack_reg       <= 1'b0;
            read_data_reg <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
        end else begin
            ack_reg       <= 1'b0;
            read_data_reg <= '0;
            case (state_reg)
                IDLE: if (bus_enable) begin
                    state_reg     <= RESP;
                    ack_reg       <= 1'b1;
                    read_data_reg <= read_data_next;
                end
                RESP: state_reg <= WAIT;
                WAIT: if (!bus_enable) state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
            if (do_flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
                count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
            end
        end
    end

    // Storage kept reset-free so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= in_data;
    end

    assign ack       = ack_reg;
    assign read_data = read_data_reg;

`ifdef HOG_BUS_IRQ_EN
    logic [1:0] irq_en_reg;
    logic       ovf_reg;
    logic       irq_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_en_reg <= 2'b00;
            ovf_reg    <= 1'b0;
            irq_reg    <= 1'b0;
        end else begin
            if (csr_wr && byte_enable[4]) irq_en_reg <= write_data[33:32];
            // A new overflow outranks a same-cycle W1C.
            if (in_valid && full) ovf_reg <= 1'b1;
            else if (csr_wr && byte_enable[8] && write_data[65]) ovf_reg <= 1'b0;
            irq_reg <= |(irq_en_reg & {ovf_reg, !empty});
        end
    end

    assign irq_en_view   = {30'h0, irq_en_reg};
    assign irq_stat_view = {30'h0, ovf_reg, !empty};
    assign irq           = irq_reg;
`else
    assign irq_en_view   = 32'h0;
    assign irq_stat_view = 32'h0;
    assign irq           = 1'b0;
`endif

endmodule

// File: tb/tb_hog_bus_responder.sv
// Directed plus randomized bench for hog_bus_responder against a queue-based model.
module tb_hog_bus_responder;
    localparam int BW    = 128;
    localparam int AW    = 5;
    localparam int DEPTH = 8;
`ifdef HOG_BUS_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] addr = '0;
    logic          bus_enable = 1'b0;
    logic          r_wbar = 1'b0;
    logic [BW-1:0] write_data = '0;
    logic [15:0]   byte_enable = '0;
    logic          ack;
    logic [BW-1:0] read_data;
    logic          irq;
    logic [BW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;

    always #5 clk = ~clk;

    hog_bus_responder #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .addr(addr), .bus_enable(bus_enable), .r_wbar(r_wbar),
        .write_data(write_data), .byte_enable(byte_enable), .ack(ack), .read_data(read_data),
        .irq(irq), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [BW-1:0] q[$];
    logic [1:0]    en_m  = 2'b00;
    logic          ovf_m = 1'b0;

    localparam logic [AW-1:0] A_FIFO = 5'h00;
    localparam logic [AW-1:0] A_CSR  = 5'h10;

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [BW-1:0] csr_model();
        logic [31:0] st, en, stt;
        st  = {16'h0, 8'(q.size()), 6'h0, q.size() == DEPTH, q.size() == 0};
        en  = IRQ_ON ? {30'h0, en_m} : 32'h0;
        stt = IRQ_ON ? {30'h0, ovf_m, q.size() != 0} : 32'h0;
        return {32'h0, stt, en, st};
    endfunction

    function automatic logic irq_model();
        return IRQ_ON && (|(en_m & {ovf_m, q.size() != 0}));
    endfunction

    function automatic logic [BW-1:0] exp_read(input logic rw, input logic [AW-1:0] a);
        if (!rw) return '0;
        if (a[4] == 1'b0) return (q.size() != 0) ? q[0] : '0;
        return csr_model();
    endfunction

    task automatic model_effect(input logic rw, input logic [AW-1:0] a,
                                input logic [BW-1:0] wd, input logic [15:0] be);
        if (rw && a[4] == 1'b0 && q.size() != 0) void'(q.pop_front());
        if (!rw && a[4] == 1'b1) begin
            if (IRQ_ON && be[4]) en_m = wd[33:32];
            if (be[8] && wd[65]) ovf_m = 1'b0;
            if (be[12] && wd[96]) q.delete();
        end
    endtask

    task automatic cycle();
        @(negedge clk);
    endtask

    task automatic xact(input logic rw, input logic [AW-1:0] a, input logic [BW-1:0] wd,
                        input logic [15:0] be, input string tag);
        logic [BW-1:0] exp;
        exp = exp_read(rw, a);
        bus_enable = 1'b1; r_wbar = rw; addr = a; write_data = wd; byte_enable = be;
        cycle();
        check({tag, ".ack"}, BW'(ack), BW'(1));
        check({tag, ".data"}, read_data, exp);
        $display("xact %s rw=%0b addr=%0h data=%h", tag, rw, a, read_data);
        model_effect(rw, a, wd, be);
        bus_enable = 1'b0;
        cycle();
        check({tag, ".ack_drop"}, BW'(ack), BW'(0));
        cycle();
    endtask

    task automatic push(input logic [BW-1:0] d);
        in_valid = 1'b1; in_data = d;
        check("push.in_ready", BW'(in_ready), BW'(q.size() < DEPTH));
        cycle();
        if (q.size() < DEPTH) q.push_back(d);
        else if (IRQ_ON) ovf_m = 1'b1;
        $display("push data=%h depth=%0d", d, q.size());
        in_valid = 1'b0;
    endtask

    task automatic check_irq(input string tag);
        cycle();
        check(tag, BW'(irq), BW'(irq_model()));
    endtask

    // Read word 0 while the pipeline offers a word in the same cycle.
    task automatic push_pop(input logic [BW-1:0] d, input string tag);
        logic [BW-1:0] exp;
        logic accept;
        exp = exp_read(1'b1, A_FIFO);
        accept = q.size() < DEPTH;
        bus_enable = 1'b1; r_wbar = 1'b1; addr = A_FIFO; in_valid = 1'b1; in_data = d;
        check({tag, ".in_ready"}, BW'(in_ready), BW'(accept));
        cycle();
        check({tag, ".ack"}, BW'(ack), BW'(1));
        check({tag, ".data"}, read_data, exp);
        $display("pushpop %s data=%h accept=%0b", tag, read_data, accept);
        if (q.size() != 0) void'(q.pop_front());
        if (accept) q.push_back(d);
        else if (IRQ_ON) ovf_m = 1'b1;
        in_valid = 1'b0; bus_enable = 1'b0;
        cycle();
        cycle();
    endtask

    initial begin
        logic [BW-1:0] wd;
        logic [BW-1:0] exp;
        logic [15:0]   be;
        int            n_ack;

        // Reset
        cycle();
        cycle();
        check("rst.ack", BW'(ack), BW'(0));
        check("rst.read_data", read_data, '0);
        check("rst.irq", BW'(irq), BW'(0));
        check("rst.in_ready", BW'(in_ready), BW'(1));
        rst = 1'b0;
        cycle();
        xact(1'b1, A_CSR, '0, '0, "rst.csr");

        // Three pushes then three pops in order, fourth read empty
        for (int i = 0; i < 3; i++) push(rnd128());
        for (int i = 0; i < 4; i++) xact(1'b1, A_FIFO, '0, '0, "fifo.read");
        xact(1'b1, A_CSR, '0, '0, "fifo.empty_csr");

        // Long bus_enable gives a single ack and a single pop
        push(rnd128());
        push(rnd128());
        exp = exp_read(1'b1, A_FIFO);
        bus_enable = 1'b1; r_wbar = 1'b1; addr = A_FIFO;
        n_ack = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (i == 0) check("hold.data", read_data, exp);
            if (ack) n_ack++;
        end
        void'(q.pop_front());
        bus_enable = 1'b0;
        cycle();
        cycle();
        check("hold.ack_count", BW'(n_ack), BW'(1));
        $display("hold acks=%0d", n_ack);
        xact(1'b1, A_CSR, '0, '0, "hold.csr");

        // Fill to full, overflow, enable overflow irq, W1C
        while (q.size() < DEPTH) push(rnd128());
        push(rnd128());
        xact(1'b1, A_CSR, '0, '0, "ovf.csr");
        wd = '0; wd[33] = 1'b1;
        xact(1'b0, A_CSR, wd, 16'h0010, "ovf.irq_en");
        check("ovf.irq", BW'(irq), BW'(irq_model()));
        wd = '0; wd[65] = 1'b1;
        xact(1'b0, A_CSR, wd, 16'h0100, "ovf.w1c");
        check("ovf.irq_clear", BW'(irq), BW'(irq_model()));

        // Same-cycle push and pop at full and just below full
        push_pop(rnd128(), "pp.full");
        push_pop(rnd128(), "pp.seven");
        xact(1'b1, A_CSR, '0, '0, "pp.csr");
        for (int i = 0; i < DEPTH + 1; i++) xact(1'b1, A_FIFO, '0, '0, "pp.drain");

        // Flush with a competing push
        for (int i = 0; i < 5; i++) push(rnd128());
        wd = '0; wd[96] = 1'b1;
        bus_enable = 1'b1; r_wbar = 1'b0; addr = A_CSR; write_data = wd; byte_enable = 16'h1000;
        in_valid = 1'b1; in_data = rnd128();
        cycle();
        check("flush.ack", BW'(ack), BW'(1));
        q.delete();
        in_valid = 1'b0; bus_enable = 1'b0;
        cycle();
        cycle();
        xact(1'b1, A_CSR, '0, '0, "flush.csr");

        // Byte-lane write touching IRQ_EN only, then not-empty interrupt
        wd = rnd128(); wd[32] = 1'b1; wd[33] = 1'b0;
        xact(1'b0, A_CSR, wd, 16'h00F0, "lane.write");
        xact(1'b1, A_CSR, '0, '0, "lane.csr");
        push(rnd128());
        check_irq("lane.irq");

        // Randomized mix
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 5))
                0, 1: push(rnd128());
                2: xact(1'b1, {1'b0, 4'($urandom)}, '0, '0, "rnd.read0");
                3: xact(1'b1, {1'b1, 4'($urandom)}, '0, '0, "rnd.csr");
                4: begin
                    wd = rnd128();
                    if ($urandom_range(0, 3) != 0) wd[96] = 1'b0;
                    be = 16'($urandom);
                    xact(1'b0, A_CSR, wd, be, "rnd.wcsr");
                end
                default: xact(1'b0, A_FIFO, rnd128(), 16'hFFFF, "rnd.wfifo");
            endcase
            check_irq("rnd.irq");
        end

        // Reset in the middle of a response
        q.delete();
        wd = '0; wd[96] = 1'b1;
        xact(1'b0, A_CSR, wd, 16'h1000, "mid.flush");
        push(rnd128());
        push(rnd128());
        bus_enable = 1'b1; r_wbar = 1'b1; addr = A_FIFO;
        cycle();
        check("mid.ack_before", BW'(ack), BW'(1));
        rst = 1'b1;
        #1;
        q.delete(); en_m = 2'b00; ovf_m = 1'b0;
        check("mid.ack", BW'(ack), BW'(0));
        check("mid.read_data", read_data, '0);
        check("mid.in_ready", BW'(in_ready), BW'(1));
        check("mid.irq", BW'(irq), BW'(0));
        cycle();
        rst = 1'b0;
        cycle();
        check("mid.restart_ack", BW'(ack), BW'(1));
        check("mid.restart_data", read_data, '0);
        bus_enable = 1'b0;
        cycle();
        cycle();
        xact(1'b1, A_CSR, '0, '0, "mid.csr");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
